// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out converter with a valid/ready input
// handshake and a one-word holding buffer. A word is shifted out MSB-first, one
// bit per clk. The holding buffer lets the next word start right after the
// current word's LSB, so back-to-back words stream with no idle bits.
module piso_serializer #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             word_last,
  output logic             busy
);

  // WIDTH is at least 2, so the counter is always at least one bit wide.
  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_nxt;
  logic [CW-1:0]    r_bit_cnt;
  logic [CW-1:0]    w_bit_cnt_nxt;
  logic             r_hold_valid;
  logic             w_hold_valid_nxt;
  logic             w_accept;
  logic             w_last_bit;

  // in_ready depends only on the holding-buffer flag, never on in_valid.
  assign w_accept   = in_valid & ~r_hold_valid;
  assign w_last_bit = (r_bit_cnt == LAST_CNT);

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_shift      <= {WIDTH{1'b0}};
      r_hold       <= {WIDTH{1'b0}};
      r_bit_cnt    <= {CW{1'b0}};
      r_hold_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_hold       <= w_hold_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_hold_valid <= w_hold_valid_nxt;
    end
  end

  // Next-state logic: load, shift, park a word in the holding buffer, or reload.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_hold_nxt       = r_hold;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_hold_valid_nxt = r_hold_valid;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift_nxt   = in_data;
          w_bit_cnt_nxt = {CW{1'b0}};
          w_state_nxt   = S_SHIFT;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last_bit) begin
          if (r_hold_valid) begin
            // Buffered word follows immediately; in_ready is low, so no accept here.
            w_shift_nxt      = r_hold;
            w_hold_valid_nxt = 1'b0;
            w_bit_cnt_nxt    = {CW{1'b0}};
          end else if (w_accept) begin
            // Word offered during the LSB cycle goes straight into the shifter.
            w_shift_nxt   = in_data;
            w_bit_cnt_nxt = {CW{1'b0}};
          end else begin
            w_bit_cnt_nxt = {CW{1'b0}};
            w_state_nxt   = S_IDLE;
          end
        end else begin
          w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (w_accept) begin
            w_hold_nxt       = in_data;
            w_hold_valid_nxt = 1'b1;
          end else begin
            w_hold_valid_nxt = r_hold_valid;
          end
        end
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_bit_cnt_nxt    = {CW{1'b0}};
        w_hold_valid_nxt = 1'b0;
      end
    endcase
  end

  // Outputs decode registered state only, so they are glitch-free at the SIPO input.
  assign in_ready   = ~r_hold_valid;
  assign serial_out = (r_state == S_SHIFT) ? r_shift[WIDTH-1] : IDLE_LEVEL;
  assign bit_valid  = (r_state == S_SHIFT);
  assign word_last  = (r_state == S_SHIFT) && w_last_bit;
  assign busy       = (r_state == S_SHIFT) || r_hold_valid;

endmodule
